// File: rtl/motor_bridge_pkg.sv
// Shared types and command encodings for the motor H-bridge receive path.
package motor_bridge_pkg;

    // Channel FSM state encoding
    typedef enum logic [2:0] {
        COAST = 3'd0,
        FWD   = 3'd1,
        REV   = 3'd2,
        BRAKE = 3'd3,
        DEAD  = 3'd4
    } state_t;

    // Raw command encodings {in1,in2}
    localparam logic [1:0] CMD_COAST = 2'b00;
    localparam logic [1:0] CMD_FWD   = 2'b10;
    localparam logic [1:0] CMD_REV   = 2'b01;
    localparam logic [1:0] CMD_BRAKE = 2'b11;

    // Relay drive pattern for a given state; DEAD coasts the bridge
    function automatic logic [1:0] state_drv(input state_t s);
        logic [1:0] d;
        case (s)
            COAST:   d = CMD_COAST;
            FWD:     d = CMD_FWD;
            REV:     d = CMD_REV;
            BRAKE:   d = CMD_BRAKE;
            DEAD:    d = CMD_COAST;
            default: d = CMD_COAST;
        endcase
        return d;
    endfunction

    // State directly named by an accepted command
    function automatic state_t cmd_state(input logic [1:0] c);
        state_t s;
        case (c)
            CMD_FWD:   s = FWD;
            CMD_REV:   s = REV;
            CMD_BRAKE: s = BRAKE;
            default:   s = COAST;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/motor_bridge_driver_channel.sv
// One motor channel: synchroniser, stability filter, reversal-safe FSM
// and registered relay/enable outputs.
module bridge_channel
    import motor_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 16,
    parameter int DEAD_CYC    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cmd,
    input  logic       pwm_on,
    output logic [1:0] drv,
    output logic       en,
    output logic       busy
);

    localparam int FCW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_CYC - 1);
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEAD_CYC - 1);

    logic [SYNC_STAGES-1:0][1:0] sync_r;
    logic [1:0]     sync_cmd_s;
    logic [1:0]     cand_r;
    logic [FCW-1:0] fcnt_r;
    logic [1:0]     req_r;
    logic [1:0]     req_eff_s;
    state_t         state_r;
    state_t         state_nxt_s;
    logic [DCW-1:0] dcnt_r;
    logic [1:0]     drv_nxt_s;
    logic           en_nxt_s;
    logic           busy_nxt_s;

    assign sync_cmd_s = sync_r[SYNC_STAGES-1];

    // Metastability synchroniser: shift each command bit through SYNC_STAGES flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{2'b00}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], cmd};
        end
    end

    // Stability filter: a command must hold FILT_CYC cycles before it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= CMD_COAST;
            fcnt_r <= {FCW{1'b0}};
            req_r  <= CMD_COAST;
        end else if (sync_cmd_s != cand_r) begin
            cand_r <= sync_cmd_s;
            fcnt_r <= {FCW{1'b0}};
        end else if (fcnt_r == FCNT_LAST) begin
            req_r <= cand_r;
        end else begin
            fcnt_r <= fcnt_r + FCW'(1);
        end
    end

    // Accepted command as it will be after this edge, so the FSM reacts on the qualifying edge
    always_comb begin
        req_eff_s = req_r;
        if ((sync_cmd_s == cand_r) && (fcnt_r == FCNT_LAST)) begin
            req_eff_s = cand_r;
        end else begin
            req_eff_s = req_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= COAST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Dead-time counter: zero on DEAD entry, counts while DEAD persists
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_r <= {DCW{1'b0}};
        end else if ((state_r == DEAD) && (state_nxt_s == DEAD)) begin
            dcnt_r <= dcnt_r + DCW'(1);
        end else begin
            dcnt_r <= {DCW{1'b0}};
        end
    end

    // Next-state logic: direct reversals are routed through DEAD
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COAST, BRAKE: begin
                state_nxt_s = cmd_state(req_eff_s);
            end
            FWD: begin
                if (req_eff_s == CMD_REV) begin
                    state_nxt_s = DEAD;
                end else begin
                    state_nxt_s = cmd_state(req_eff_s);
                end
            end
            REV: begin
                if (req_eff_s == CMD_FWD) begin
                    state_nxt_s = DEAD;
                end else begin
                    state_nxt_s = cmd_state(req_eff_s);
                end
            end
            DEAD: begin
                if (dcnt_r == DCNT_LAST) begin
                    state_nxt_s = cmd_state(req_eff_s);
                end else begin
                    state_nxt_s = DEAD;
                end
            end
            default: begin
                state_nxt_s = COAST;
            end
        endcase
    end

    // Output decode from the next state so outputs register alongside the state
    always_comb begin
        drv_nxt_s  = state_drv(state_nxt_s);
        busy_nxt_s = (state_nxt_s == DEAD);
        case (state_nxt_s)
            FWD, REV: en_nxt_s = pwm_on;
            BRAKE:    en_nxt_s = 1'b1;
            default:  en_nxt_s = 1'b0;
        endcase
    end

    // Registered relay, enable and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv  <= CMD_COAST;
            en   <= 1'b0;
            busy <= 1'b0;
        end else begin
            drv  <= drv_nxt_s;
            en   <= en_nxt_s;
            busy <= busy_nxt_s;
        end
    end

endmodule

// File: rtl/motor_bridge_driver.sv
// Two-channel motor bridge driver with a shared PWM timebase.
module motor_bridge_driver
    import motor_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 16,
    parameter int DEAD_CYC    = 1000,
    parameter int PWM_PERIOD  = 256,
    parameter int PWM_DUTY    = 192
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cmd_a,
    input  logic [1:0] cmd_b,
    output logic [1:0] drv_a,
    output logic [1:0] drv_b,
    output logic       en_a,
    output logic       en_b,
    output logic       busy_a,
    output logic       busy_b
);

    localparam int PCW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [PCW-1:0] PCNT_LAST = PCW'(PWM_PERIOD - 1);
    localparam logic [31:0]    DUTY_U    = 32'(PWM_DUTY);

    logic [PCW-1:0] pcnt_r;
    logic           pwm_on_s;

    // Free-running PWM period counter shared by both channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= {PCW{1'b0}};
        end else if (pcnt_r == PCNT_LAST) begin
            pcnt_r <= {PCW{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + PCW'(1);
        end
    end

    assign pwm_on_s = ({{(32-PCW){1'b0}}, pcnt_r} < DUTY_U);

    bridge_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYC   (FILT_CYC),
        .DEAD_CYC   (DEAD_CYC)
    ) u_chan_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd    (cmd_a),
        .pwm_on (pwm_on_s),
        .drv    (drv_a),
        .en     (en_a),
        .busy   (busy_a)
    );

    bridge_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYC   (FILT_CYC),
        .DEAD_CYC   (DEAD_CYC)
    ) u_chan_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd    (cmd_b),
        .pwm_on (pwm_on_s),
        .drv    (drv_b),
        .en     (en_b),
        .busy   (busy_b)
    );

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Self-checking bench for motor_bridge_driver at default parameters.
module tb_motor_bridge_driver;

    localparam int LAT    = 19;
    localparam int DEAD_N = 1000;
    localparam int PERIOD = 256;
    localparam int DUTY   = 192;

    logic       clk;
    logic       rst_n;
    logic [1:0] cmd_a;
    logic [1:0] cmd_b;
    logic [1:0] drv_a;
    logic [1:0] drv_b;
    logic       en_a;
    logic       en_b;
    logic       busy_a;
    logic       busy_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] ca;
        logic [1:0] cb;
        logic [1:0] da;
        logic [1:0] db;
        int         ena;
        int         enb;
    } vec_t;

    vec_t vecs[5];
    vec_t sb[$];

    motor_bridge_driver dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd_a  (cmd_a),
        .cmd_b  (cmd_b),
        .drv_a  (drv_a),
        .drv_b  (drv_b),
        .en_a   (en_a),
        .en_b   (en_b),
        .busy_a (busy_a),
        .busy_b (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance n rising edges, landing on the following falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vec_t       e;
        logic [1:0] prev_a;
        logic [1:0] prev_b;
        int         cnt_a;
        int         cnt_b;
        int         busy_seen;
        int         n;
        int         viol;

        vecs[0] = '{ca: 2'b10, cb: 2'b00, da: 2'b10, db: 2'b00, ena: DUTY,   enb: 0};
        vecs[1] = '{ca: 2'b11, cb: 2'b01, da: 2'b11, db: 2'b01, ena: PERIOD, enb: DUTY};
        vecs[2] = '{ca: 2'b01, cb: 2'b11, da: 2'b01, db: 2'b11, ena: DUTY,   enb: PERIOD};
        vecs[3] = '{ca: 2'b00, cb: 2'b10, da: 2'b00, db: 2'b10, ena: 0,      enb: DUTY};
        vecs[4] = '{ca: 2'b00, cb: 2'b00, da: 2'b00, db: 2'b00, ena: 0,      enb: 0};

        rst_n = 1'b0;
        cmd_a = 2'b00;
        cmd_b = 2'b00;
        tick(3);
        check("reset_outs", {24'd0, drv_a, drv_b, en_a, en_b, busy_a, busy_b}, 32'd0);
        rst_n = 1'b1;
        tick(5);
        check("post_reset_outs", {24'd0, drv_a, drv_b, en_a, en_b, busy_a, busy_b}, 32'd0);

        // table: steady commands, latency edge and PWM duty per vector
        for (int i = 0; i < 5; i++) begin
            prev_a = drv_a;
            prev_b = drv_b;
            cmd_a = vecs[i].ca;
            cmd_b = vecs[i].cb;
            sb.push_back(vecs[i]);
            tick(LAT - 1);
            check($sformatf("v%0d_early_a", i), {30'd0, drv_a}, {30'd0, prev_a});
            check($sformatf("v%0d_early_b", i), {30'd0, drv_b}, {30'd0, prev_b});
            tick(1);
            e = sb.pop_front();
            check($sformatf("v%0d_drv_a", i), {30'd0, drv_a}, {30'd0, e.da});
            check($sformatf("v%0d_drv_b", i), {30'd0, drv_b}, {30'd0, e.db});
            cnt_a = 0;
            cnt_b = 0;
            busy_seen = 0;
            for (int c = 0; c < PERIOD; c++) begin
                cnt_a += int'(en_a);
                cnt_b += int'(en_b);
                if (busy_a || busy_b) busy_seen++;
                tick(1);
            end
            check($sformatf("v%0d_en_a_cnt", i), cnt_a, e.ena);
            check($sformatf("v%0d_en_b_cnt", i), cnt_b, e.enb);
            check($sformatf("v%0d_busy", i), busy_seen, 0);
        end

        // glitch shorter than the filter window is ignored
        viol = 0;
        cmd_a = 2'b10;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) cmd_a = 2'b00;
            if (drv_a != 2'b00 || en_a) viol++;
            tick(1);
        end
        check("glitch_ignored", viol, 0);

        // reversal FWD -> REV goes through exactly DEAD_N cycles of coast
        cmd_a = 2'b10;
        tick(LAT + 5);
        check("rev_pre_fwd", {30'd0, drv_a}, 32'd2);
        cmd_a = 2'b01;
        tick(LAT - 1);
        check("rev_early_drv", {30'd0, drv_a}, 32'd2);
        check("rev_early_busy", {31'd0, busy_a}, 32'd0);
        tick(1);
        check("rev_dead_drv", {30'd0, drv_a}, 32'd0);
        check("rev_dead_busy", {31'd0, busy_a}, 32'd1);
        n = 0;
        viol = 0;
        while (busy_a && n < 2000) begin
            if (drv_a != 2'b00 || en_a) viol++;
            n++;
            tick(1);
        end
        check("rev_dead_len", n, DEAD_N);
        check("rev_dead_coast", viol, 0);
        check("rev_after_drv", {30'd0, drv_a}, 32'd1);
        cnt_a = 0;
        for (int c = 0; c < PERIOD; c++) begin
            cnt_a += int'(en_a);
            tick(1);
        end
        check("rev_pwm", cnt_a, DUTY);

        // abort to coast mid-DEAD: DEAD still runs full length, no forward pulse
        cmd_a = 2'b10;
        tick(LAT);
        check("abort_dead_busy", {31'd0, busy_a}, 32'd1);
        n = 0;
        viol = 0;
        while (busy_a && n < 2000) begin
            if (n == 100) cmd_a = 2'b00;
            if (drv_a != 2'b00) viol++;
            n++;
            tick(1);
        end
        check("abort_dead_len", n, DEAD_N);
        for (int c = 0; c < 40; c++) begin
            if (drv_a != 2'b00 || en_a || busy_a) viol++;
            tick(1);
        end
        check("abort_no_pulse", viol, 0);

        // brake is entered and left without dead time
        cmd_a = 2'b10;
        tick(LAT + 5);
        busy_seen = 0;
        cmd_a = 2'b11;
        for (int c = 0; c < LAT + 5; c++) begin
            if (busy_a) busy_seen++;
            tick(1);
        end
        check("brake_drv", {30'd0, drv_a}, 32'd3);
        check("brake_en", {31'd0, en_a}, 32'd1);
        cmd_a = 2'b01;
        for (int c = 0; c < LAT - 1; c++) begin
            if (busy_a) busy_seen++;
            tick(1);
        end
        check("brake_early", {30'd0, drv_a}, 32'd3);
        tick(1);
        check("brake_to_rev", {30'd0, drv_a}, 32'd1);
        check("brake_no_busy", busy_seen, 0);

        // async reset mid-DEAD on A while B runs reverse
        cmd_a = 2'b10;
        cmd_b = 2'b01;
        tick(LAT + 50);
        check("arst_pre_busy_a", {31'd0, busy_a}, 32'd1);
        check("arst_pre_drv_b", {30'd0, drv_b}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_immediate", {24'd0, drv_a, drv_b, en_a, en_b, busy_a, busy_b}, 32'd0);
        tick(3);
        cmd_a = 2'b00;
        rst_n = 1'b1;
        tick(LAT - 1);
        check("arst_b_early", {30'd0, drv_b}, 32'd0);
        tick(1);
        check("arst_b_rev", {30'd0, drv_b}, 32'd1);
        check("arst_a_idle", {29'd0, drv_a, busy_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_bridge_driver.md
Name: motor_bridge_driver

Overview:
Receive end of the motor command interface. Takes the raw 2-bit H-bridge/relay commands per motor, which are combinational and glitch-prone. Synchronises and filters them, then drives the relay module through a per-channel FSM. The FSM enforces a dead time on any FWD<->REV reversal and gates a PWM enable. Two identical channels (A = motor 1, B = motor 2) share one PWM timebase.

Parameters:
SYNC_STAGES, 2, synchroniser depth on each cmd bit (>=2)
FILT_CYC, 16, consecutive stable cycles required before a command is accepted (>=1)
DEAD_CYC, 1000, coast cycles inserted on direction reversal (>=1)
PWM_PERIOD, 256, PWM counter period in clk cycles (>=2)
PWM_DUTY, 192, enable-high cycles per period; >=PWM_PERIOD means always on, 0 means always off

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_a  input  2  motor A command {in1,in2}: 00 coast, 10 fwd, 01 rev, 11 brake
cmd_b  input  2  motor B command, same encoding
drv_a  output  2  motor A relay drive {in1,in2}, registered
drv_b  output  2  motor B relay drive, registered
en_a  output  1  motor A enable/PWM, registered
en_b  output  1  motor B enable/PWM, registered
busy_a  output  1  high while channel A is in DEAD
busy_b  output  1  high while channel B is in DEAD

Behaviour:
- One clock; reset asynchronous active-low. While rst_n=0 every flop clears: drv=00, en=0, busy=0, state=COAST, sync flops=0, candidate=00, accepted=00, counters=0.
- Sync: each cmd bit passes through SYNC_STAGES flops to give sync_cmd.
- Filter:
  - If sync_cmd != cand: cand<=sync_cmd, fcnt<=0.
  - Else if fcnt==FILT_CYC-1: req<=cand.
  - Else fcnt++.
  - Pulses shorter than FILT_CYC cycles after sync are never accepted.
- Latency: input change to drv change, with no dead time needed, is exactly SYNC_STAGES+FILT_CYC+1 rising edges (19 at defaults).
- FSM states and outputs:
  - COAST: drv=00
  - FWD: drv=10
  - REV: drv=01
  - BRAKE: drv=11
  - DEAD: drv=00, busy=1
- Transitions (evaluated each cycle on req):
  - COAST and BRAKE move directly to the state named by req.
  - FWD: req REV -> DEAD (dcnt<=0); req COAST/BRAKE -> that state directly.
  - REV: mirror of FWD (req FWD -> DEAD).
  - DEAD: dcnt++ each cycle. On the cycle dcnt==DEAD_CYC-1, move to the state named by the current req, whatever its value.
  - DEAD always runs the full DEAD_CYC cycles. req changes during DEAD are not acted on early.
- Drive rule: drv never goes from 10 to 01 or from 01 to 10 without at least DEAD_CYC cycles of 00 between.
- PWM timebase:
  - Shared pcnt counts 0..PWM_PERIOD-1, wraps to 0, runs continuously after reset.
  - en = (state in FWD/REV) && (pcnt < PWM_DUTY).
  - en = 1 in BRAKE.
  - en = 0 in COAST/DEAD.
  - en is registered with the same timing as drv.
- Widths: dcnt, fcnt and pcnt are each $clog2 of their limit, minimum 1 bit. No saturation is needed because comparisons reset them.
- Channels are fully independent except for the shared pcnt.
- Reset asserted mid-DEAD or mid-filter: outputs go to 00/0 immediately. After release the channel restarts in COAST with a cleared filter, so a held command re-qualifies with full latency.

Decomposition:
- Package motor_bridge_pkg holds:
  - state encoding typedef (COAST, FWD, REV, BRAKE, DEAD)
  - command localparams CMD_COAST=2'b00, CMD_FWD=2'b10, CMD_REV=2'b01, CMD_BRAKE=2'b11
- Sub-module bridge_channel contains sync + filter + FSM + output regs.
  - Instantiated twice.
  - Takes pwm_on (pcnt<PWM_DUTY) from the top.
- Top holds only pcnt and the instantiations.

Test Plan:
1. Reset, then cmd_a=10 held: drv_a=10 on edge 19 after the change. en_a is high for exactly 192 of every 256 cycles. drv_b=00, en_b=0.
2. Glitch: cmd_a=10 for 10 cycles, then back to 00: drv_a stays 00 and en_a stays 0 throughout.
3. Reversal: channel A in FWD, cmd_a set to 01: after 19 edges drv_a=00 and busy_a=1 for exactly 1000 cycles, then drv_a=01, busy_a=0 and PWM resumes.
4. Abort to coast: during DEAD, cmd_a changes to 00 and qualifies: DEAD still lasts 1000 cycles, then drv_a=00 with no 01 pulse.
5. Brake: FWD, then cmd_a=11: drv_a=11 and en_a=1 with no DEAD (busy_a never 1). Then cmd_a=01: drv_a=01 directly.
6. Async reset: rst_n=0 mid-DEAD on A while B is in REV: all outputs go to 0 before the next clk edge. After release with cmd_b=01 held, drv_b=01 after 19 edges.
